// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl shared definitions: state encoding,
// UART address map and status flag bit layout.
package mem_bus_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, SRD, SWR, SWR_HOLD, UWAIT_W,
    UWR, UWAIT_R, URD, FLAG, DONE
  } state_t;

  localparam logic [31:0] UART_ADDR_DEF = 32'hBFD003F8;

  localparam int FLAG_TX_BIT = 0;
  localparam int FLAG_RX_BIT = 1;

  function automatic logic [31:0] flag_word(
    input logic rx,
    input logic tx
  );
    logic [31:0] w;
    w = '0;
    w[FLAG_RX_BIT] = rx;
    w[FLAG_TX_BIT] = tx;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester-side handshake bundle of mem_bus_ctrl:
// request/address/data in, read data and ack out.
interface mem_bus_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, sel_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, sel_i, data_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/mbc_cycle_cnt.sv
// 4-bit load/decrement counter timing the wait
// and strobe-pulse states; zero marks the last cycle.
module mbc_cycle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;

  // load wins over decrement; saturate at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 4'd0;
    else if (load) cnt <= val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);
endmodule

// File: rtl/mem_bus_ctrl.sv
// SRAM + UART bus controller; define MEM_BUS_CTRL_UART_EN
// to decode the UART window, otherwise everything is SRAM.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 20,
  parameter int          RD_WAIT    = 1,
  parameter int          WR_WAIT    = 1,
  parameter int          UART_PULSE = 2,
  parameter logic [31:0] UART_ADDR  = UART_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_ctrl_if.slave     bus,
  inout  wire  [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  input  logic              tbre,
  input  logic              tsre,
  input  logic              data_ready,
  output logic              rdn,
  output logic              wrn
);
  localparam logic [3:0] RD_LD = 4'(RD_WAIT);
  localparam logic [3:0] WR_LD = 4'(WR_WAIT);
  localparam logic [3:0] UP_LD = 4'(UART_PULSE - 1);

  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]  sel_q, sel_nxt;
  logic [31:0] data_q, rd_q;
  logic ack_q, drv_hi, drv_lo;
  logic latch, cap_mem, cap_uart, cap_flag;
  logic cnt_load, cnt_dec, cnt_zero;
  logic [3:0] cnt_val;
  logic uart_hit, tx_ok;
  logic ce_n_d, oe_n_d, we_n_d, rdn_d, wrn_d;
  logic drv_hi_d, drv_lo_d;
  logic [3:0] be_n_d;

`ifdef MEM_BUS_CTRL_UART_EN
  assign uart_hit = bus.addr_i[31:3] == UART_ADDR[31:3];
`else
  assign uart_hit = 1'b0;
`endif

  assign tx_ok = tbre & tsre;
  assign sel_nxt = latch ? bus.sel_i : sel_q;

  mbc_cycle_cnt u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .val  (cnt_val),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // next-state decode and counter/capture control
  always_comb begin
    nxt      = state;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = 4'd0;
    cnt_dec  = 1'b0;
    cap_mem  = 1'b0;
    cap_uart = 1'b0;
    cap_flag = 1'b0;
    unique case (state)
      IDLE: if (bus.req_i) begin
        latch = 1'b1;
        if (uart_hit && bus.addr_i[2]) nxt = FLAG;
        else if (uart_hit) nxt = bus.we_i ? UWAIT_W : UWAIT_R;
        else if (!bus.we_i) begin
          nxt = SRD; cnt_load = 1'b1; cnt_val = RD_LD;
        end
        else if (bus.sel_i == 4'b0000) nxt = DONE;
        else begin
          nxt = SWR; cnt_load = 1'b1; cnt_val = WR_LD;
        end
      end
      SRD:
        if (cnt_zero) begin cap_mem = 1'b1; nxt = DONE; end
        else cnt_dec = 1'b1;
      SWR:
        if (cnt_zero) nxt = SWR_HOLD;
        else cnt_dec = 1'b1;
      SWR_HOLD: nxt = DONE;
      UWAIT_W: if (tx_ok) begin
        nxt = UWR; cnt_load = 1'b1; cnt_val = UP_LD;
      end
      UWR:
        if (cnt_zero) nxt = DONE;
        else cnt_dec = 1'b1;
      UWAIT_R: if (data_ready) begin
        nxt = URD; cnt_load = 1'b1; cnt_val = UP_LD;
      end
      URD:
        if (cnt_zero) begin cap_uart = 1'b1; nxt = DONE; end
        else cnt_dec = 1'b1;
      FLAG: begin cap_flag = 1'b1; nxt = DONE; end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // strobe levels for the upcoming state, registered below
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    be_n_d   = 4'hF;
    drv_hi_d = 1'b0;
    drv_lo_d = 1'b0;
    rdn_d    = 1'b1;
    wrn_d    = 1'b1;
    unique case (nxt)
      SRD: begin
        ce_n_d = 1'b0; oe_n_d = 1'b0; be_n_d = 4'h0;
      end
      SWR: begin
        ce_n_d = 1'b0; we_n_d = 1'b0; be_n_d = ~sel_nxt;
        drv_hi_d = 1'b1; drv_lo_d = 1'b1;
      end
      SWR_HOLD: begin
        ce_n_d = 1'b0; be_n_d = ~sel_nxt;
        drv_hi_d = 1'b1; drv_lo_d = 1'b1;
      end
`ifdef MEM_BUS_CTRL_UART_EN
      UWR: begin drv_lo_d = 1'b1; wrn_d = 1'b0; end
      URD: rdn_d = 1'b0;
`endif
      default: ;
    endcase
  end

  // state and glitch-free registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_be_n <= 4'hF;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      drv_hi   <= 1'b0;
      drv_lo   <= 1'b0;
    end else begin
      state    <= nxt;
      ack_q    <= (nxt == DONE);
      ram_ce_n <= ce_n_d;
      ram_oe_n <= oe_n_d;
      ram_we_n <= we_n_d;
      ram_be_n <= be_n_d;
      rdn      <= rdn_d;
      wrn      <= wrn_d;
      drv_hi   <= drv_hi_d;
      drv_lo   <= drv_lo_d;
    end
  end

  // request capture and read-data return register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      sel_q  <= 4'h0;
      data_q <= 32'h0;
      rd_q   <= 32'h0;
    end else begin
      if (latch) begin
        addr_q <= bus.addr_i[ADDR_W+1:2];
        sel_q  <= bus.sel_i;
        data_q <= bus.data_i;
      end
      if (cap_mem) rd_q <= ram_data;
      else if (cap_uart) rd_q <= {24'h0, ram_data[7:0]};
      else if (cap_flag) rd_q <= flag_word(data_ready, tx_ok);
    end
  end

  assign ram_addr = addr_q;
  assign ram_data[31:8] = drv_hi ? data_q[31:8] : 24'bz;
  assign ram_data[7:0] = drv_lo ? data_q[7:0] : 8'bz;
  assign bus.data_o = rd_q;
  assign bus.ack_o = ack_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: vector table, hand-written
// UART/reset sequences, random traffic vs reference memory.
module tb_mem_bus_ctrl;
  localparam int AW = 20;
  localparam int RDW = 1;
  localparam int WRW = 1;
  localparam int UPW = 2;
  localparam logic [31:0] UA = 32'hBFD003F8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tbre = 1'b1, tsre = 1'b1, data_ready = 1'b0;
  logic rdn, wrn, ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0] ram_be_n;
  logic [AW-1:0] ram_addr;
  wire [31:0] ram_data;
  logic [7:0] rx_byte = 8'h00;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(
    .ADDR_W(AW), .RD_WAIT(RDW), .WR_WAIT(WRW),
    .UART_PULSE(UPW), .UART_ADDR(UA)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_data(ram_data), .ram_addr(ram_addr),
    .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
    .rdn(rdn), .wrn(wrn)
  );

  always #5 clk = ~clk;

  // SRAM device and UART receive-data source
  logic [31:0] sram [0:255];
  logic pre_en = 1'b0;
  logic [7:0] pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;
  wire sram_rd = !ram_ce_n && !ram_oe_n;
  assign ram_data = sram_rd ? sram[ram_addr[7:0]] :
                    !rdn ? {24'hFFFFFF, rx_byte} : 32'bz;

  always @(posedge clk) begin
    if (pre_en) sram[pre_idx] <= pre_val;
    else if (!ram_ce_n && !ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b])
          sram[ram_addr[7:0]][b*8 +: 8] <= ram_data[b*8 +: 8];
  end

  // reference model: plain word memory with byte merge
  logic [31:0] ref_mem [0:255];
  int checks = 0, errors = 0;

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic int ones(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // observations of one transaction
  int o_lat, o_oe, o_we, o_hold, o_wrn, o_rdn;
  logic [31:0] o_rd;
  logic [7:0] o_tx;
  logic o_addr_ok, o_be_ok, o_wd_ok, o_uwr_ok;

  task automatic run_txn(input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    o_lat = -1; o_oe = 0; o_we = 0; o_hold = 0;
    o_wrn = 0; o_rdn = 0; o_rd = 32'h0; o_tx = 8'h0;
    o_addr_ok = 1; o_be_ok = 1; o_wd_ok = 1; o_uwr_ok = 1;
    bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a;
    bus.sel_i = s; bus.data_i = d;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (!ram_ce_n && ram_addr !== a[AW+1:2]) o_addr_ok = 0;
      if (!ram_oe_n) o_oe++;
      if (!ram_we_n) begin
        o_we++;
        if (ram_be_n !== ~s) o_be_ok = 0;
        if (ram_data !== d) o_wd_ok = 0;
      end
      if (!ram_ce_n && ram_we_n && ram_oe_n &&
          ram_data === d && ram_be_n === ~s) o_hold++;
      if (!wrn) begin
        o_wrn++;
        o_tx = ram_data[7:0];
        if (ones(ram_data & 32'hFFFFFF00) != 0 || !ram_ce_n)
          o_uwr_ok = 0;
      end
      if (!rdn) o_rdn++;
      if (bus.ack_o) begin
        o_lat = n; o_rd = bus.data_o; break;
      end
    end
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", {31'h0, bus.ack_o}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          lat;
    int          oe;
    int          wen;
    int          hold;
  } vec_t;

  vec_t vt [7];
  int nack;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 32'h80000010, 4'hF, 32'h0, 32'hDEADBEEF, 3, 2, 0, 0};
    vt[1] = '{1, 32'h80000020, 4'h3, 32'h12345678, 32'h0, 4, 0, 2, 1};
    vt[2] = '{0, 32'h80000020, 4'hF, 32'h0, 32'hAAAA5678, 3, 2, 0, 0};
    vt[3] = '{1, 32'h80000020, 4'h0, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0};
    vt[4] = '{0, 32'h80000022, 4'hF, 32'h0, 32'hAAAA5678, 3, 2, 0, 0};
    vt[5] = '{1, 32'h80000024, 4'h8, 32'h11223344, 32'h0, 4, 0, 2, 1};
    vt[6] = '{0, 32'h80000024, 4'hF, 32'h0, 32'h11000000, 3, 2, 0, 0};

    bus.req_i = 0; bus.we_i = 0; bus.addr_i = 0;
    bus.sel_i = 0; bus.data_i = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;
    ref_mem[8] = 32'hAAAAAAAA;
    ref_mem[9] = 32'h0;

    // preload the SRAM device while reset is held
    pre_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_idx = 8'(i); pre_val = ref_mem[i];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;

    chk("rst_ack", {31'h0, bus.ack_o}, 32'h0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_strobes", {27'h0, ram_ce_n, ram_oe_n, ram_we_n, rdn, wrn},
        32'h1F);
    chk("rst_be", {28'h0, ram_be_n}, 32'hF);
    chk("rst_bus_z", ones(ram_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].we, vt[i].addr, vt[i].sel, vt[i].data);
      chk($sformatf("vec%0d_lat", i), o_lat, vt[i].lat);
      chk($sformatf("vec%0d_oe", i), o_oe, vt[i].oe);
      chk($sformatf("vec%0d_we", i), o_we, vt[i].wen);
      chk($sformatf("vec%0d_hold", i), o_hold, vt[i].hold);
      chk($sformatf("vec%0d_addr", i), {31'h0, o_addr_ok}, 1);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_be", i), {31'h0, o_be_ok}, 1);
        chk($sformatf("vec%0d_wdata", i), {31'h0, o_wd_ok}, 1);
        ref_mem[widx(vt[i].addr)] =
          merge(ref_mem[widx(vt[i].addr)], vt[i].data, vt[i].sel);
      end else
        chk($sformatf("vec%0d_rdata", i), o_rd, vt[i].exp_rd);
    end

`ifdef MEM_BUS_CTRL_UART_EN
    tbre = 1'b0; tsre = 1'b1;
    fork
      run_txn(1, UA, 4'hF, 32'hFFFFFF41);
      begin repeat (5) @(posedge clk); #2 tbre = 1'b1; end
    join
    chk("uwr_lat", o_lat, 8);
    chk("uwr_pulse", o_wrn, UPW);
    chk("uwr_byte", {24'h0, o_tx}, 32'h41);
    chk("uwr_upper_z", {31'h0, o_uwr_ok}, 1);
    data_ready = 1'b0; rx_byte = 8'h5A;
    fork
      run_txn(0, UA, 4'hF, 32'h0);
      begin repeat (3) @(posedge clk); #2 data_ready = 1'b1; end
    join
    chk("urd_lat", o_lat, 6);
    chk("urd_pulse", o_rdn, UPW);
    chk("urd_data", o_rd, 32'h0000005A);
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
    run_txn(0, UA + 32'd4, 4'hF, 32'h0);
    chk("flag11_lat", o_lat, 2);
    chk("flag11_data", o_rd, 32'h3);
    data_ready = 1'b0; tsre = 1'b0;
    run_txn(0, UA + 32'd4, 4'hF, 32'h0);
    chk("flag00_data", o_rd, 32'h0);
    data_ready = 1'b1;
    run_txn(0, UA + 32'd4, 4'hF, 32'h0);
    chk("flag10_data", o_rd, 32'h2);
    data_ready = 1'b0; tsre = 1'b1;
`else
    run_txn(1, UA, 4'hF, 32'hFFFFFF41);
    chk("nouart_wr_lat", o_lat, WRW + 3);
    chk("nouart_wr_we", o_we, WRW + 1);
    chk("nouart_wrn", o_wrn, 0);
    ref_mem[widx(UA)] = 32'hFFFFFF41;
    data_ready = 1'b1;
    run_txn(0, UA + 32'd4, 4'hF, 32'h0);
    chk("nouart_flag_lat", o_lat, RDW + 2);
    chk("nouart_flag_data", o_rd, ref_mem[widx(UA + 32'd4)]);
    chk("nouart_rdn", o_rdn, 0);
    data_ready = 1'b0;
    run_txn(0, UA, 4'hF, 32'h0);
    chk("nouart_rdback", o_rd, 32'hFFFFFF41);
`endif

    // reset in the first SWR cycle drops the write
    bus.req_i = 1'b1; bus.we_i = 1'b1;
    bus.addr_i = 32'h80000028; bus.sel_i = 4'hF;
    bus.data_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("swr_we_low", {31'h0, ram_we_n}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we", {30'h0, ram_we_n, ram_ce_n}, 32'h3);
    chk("rst_mid_z", ones(ram_data), 0);
    chk("rst_mid_ack", {31'h0, bus.ack_o}, 32'h0);
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) nack++;
    end
    chk("rst_no_ack", nack, 0);
    run_txn(0, 32'h80000028, 4'hF, 32'h0);
    chk("rst_after_lat", o_lat, RDW + 2);
    chk("rst_after_data", o_rd, ref_mem[10]);

    // random traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      logic w;
      logic [3:0] s;
      logic [31:0] d, a;
      logic [7:0] wi;
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      wi = 8'($urandom_range(0, 63));
      a = 32'h80000000 | {22'h0, wi, 2'b00} | 32'($urandom_range(0, 3));
      run_txn(w, a, s, d);
      chk($sformatf("rnd%0d_addr", i), {31'h0, o_addr_ok}, 1);
      if (!w) begin
        chk($sformatf("rnd%0d_lat", i), o_lat, RDW + 2);
        chk($sformatf("rnd%0d_oe", i), o_oe, RDW + 1);
        chk($sformatf("rnd%0d_rd", i), o_rd, ref_mem[wi]);
      end else begin
        chk($sformatf("rnd%0d_lat", i), o_lat,
            (s == 4'h0) ? 1 : WRW + 3);
        chk($sformatf("rnd%0d_we", i), o_we,
            (s == 4'h0) ? 0 : WRW + 1);
        chk($sformatf("rnd%0d_be", i), {31'h0, o_be_ok}, 1);
        ref_mem[wi] = merge(ref_mem[wi], d, s);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 SHALL have parameter RD_WAIT, default 1, extra SRAM read cycles (0..15).
REQ-003 SHALL have parameter WR_WAIT, default 1, extra SRAM ram_we_n-low cycles (0..15).
REQ-004 SHALL have parameter UART_PULSE, default 2, rdn/wrn low width in cycles (1..15); UART_ADDR, default 32'hBFD003F8, UART data address; UART_ADDR+4 is the flag address.
REQ-005 SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst input 1, asynchronous active-high reset.
REQ-007 SHALL have ports req_i input 1 (request), we_i input 1 (1 = write) and addr_i input 32 (byte address).
REQ-008 SHALL have ports sel_i input 4 (byte enables, active-high) and data_i input 32 (write data).
REQ-009 SHALL have ports data_o output 32 (read data) and ack_o output 1 (one-cycle completion pulse).
REQ-010 SHALL have port ram_data inout 32, the shared SRAM/UART data bus.
REQ-011 SHALL have ports ram_addr output ADDR_W and ram_be_n output 4 (active-low byte enables).
REQ-012 SHALL have ports ram_ce_n, ram_oe_n and ram_we_n, each output 1, active-low.
REQ-013 SHALL have ports tbre, tsre and data_ready, each input 1 (UART status); rdn and wrn, each output 1 (UART strobes, active-low).

Function
REQ-014 SHALL use the states IDLE, SRD, SWR, SWR_HOLD, UWAIT_W, UWR, UWAIT_R, URD, FLAG and DONE.
REQ-015 In IDLE with req_i=1, SHALL register addr/we/sel/data and go to FLAG if addr_i[31:3]==UART_ADDR[31:3] and addr_i[2]=1; to UWAIT_R/UWAIT_W if addr_i[2]=0; otherwise to SRD/SWR.
REQ-016 SHALL ignore req_i outside IDLE; the requester holds inputs until ack_o.
REQ-017 SHALL drive ram_addr = registered addr[ADDR_W+1:2] in every SRAM state.
REQ-018 SRD: ram_ce_n=0 and ram_oe_n=0 for RD_WAIT+1 cycles; SHALL capture ram_data into data_o on the last cycle, then go to DONE. Ack arrives RD_WAIT+2 cycles after request acceptance.
REQ-019 SWR: SHALL drive ram_data=data and ram_be_n=~sel, with ram_ce_n=0 and ram_we_n=0 for WR_WAIT+1 cycles; SWR_HOLD SHALL hold ram_we_n=1 with data still driven for one cycle, then go to DONE.
REQ-020 If sel=4'b0000 on a write, SHALL skip SWR/SWR_HOLD, keep ram_we_n=1 and go directly to DONE.
REQ-021 UWAIT_W: SHALL wait until tbre&tsre=1, then UWR SHALL drive wrn=0 for UART_PULSE cycles with ram_data[7:0]=data[7:0], upper bits Z and ram_ce_n=1.
REQ-022 UWAIT_R: SHALL wait until data_ready=1, then URD SHALL drive rdn=0 for UART_PULSE cycles and capture {24'b0, ram_data[7:0]} on the last cycle.
REQ-023 FLAG: SHALL take one cycle and load data_o={30'b0, data_ready, tbre&tsre}.
REQ-024 DONE: SHALL assert ack_o=1 for exactly one cycle, then return to IDLE; data_o holds until the next read capture.
REQ-025 ram_data SHALL be Z in every state except SWR, SWR_HOLD and UWR; all strobes SHALL be registered and glitch-free.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, ack_o=0, data_o=0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_be_n=4'hF, rdn=wrn=1 and ram_data=Z, including in the middle of an operation.
REQ-027 A transaction interrupted by reset SHALL be dropped and never acked.

Configuration
REQ-028 With MEM_BUS_CTRL_UART_EN defined, UART decode per REQ-015 and REQ-021..023 SHALL apply.
REQ-029 Without MEM_BUS_CTRL_UART_EN, all addresses SHALL go to the SRAM path, and rdn/wrn SHALL be tied to 1.

Structure
REQ-030 State encoding, UART_ADDR and the flag bit positions SHALL live in the shared defines package.
REQ-031 One sub-module, mbc_cycle_cnt (a 4-bit load/decrement counter with a zero flag), SHALL time the wait and pulse states.

Verification
REQ-032 Read 0x80000010 with RD_WAIT=1 and SRAM=0xDEADBEEF -> ram_addr=0x00004, oe_n low 2 cycles, ack on cycle 3, data_o=0xDEADBEEF.
REQ-033 Write 0x80000020 with sel=4'b0011 and data 0x12345678 -> ram_be_n=4'b1100, we_n low 2 cycles then high 1 cycle with data held, one ack.
REQ-034 UART write 0x41 with tbre=0 for 5 cycles -> wrn stays 1 until tbre&tsre=1, then low 2 cycles, ram_data[7:0]=0x41, upper bits Z.
REQ-035 Flag read at UART_ADDR+4 with data_ready=1 and tbre=tsre=1 -> data_o=0x00000003 and ack 2 cycles after the request.
REQ-036 Assert rst during cycle 1 of SWR -> ram_we_n=1 and ram_data=Z within the same cycle, no ack, and the next request is served normally.
